// File: rtl/fifo_pkg.sv
// Shared constants, status-flag payload and sizing helper for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 16;
    localparam int unsigned FIFO_DEPTH  = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FIFO_FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // LEVEL must represent 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int unsigned fifo_level_w(input int unsigned depth);
        return 32'($clog2(depth) + 1);
    endfunction

endpackage

// File: rtl/fifo_strobe_gen.sv
// Turns a request level into a one-cycle request on its rising edge, or passes it through.
module fifo_strobe_gen #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_c
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign pulse_c = EDGE_MODE ? (level_i & ~level_q) : level_i;

endmodule

// File: rtl/param_fifo_sync.sv
// Single-clock parameterised FIFO with registered flags, sticky error bits and
// optional first-word-fall-through read port.
module param_fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = FIFO_DATA_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL  = DEPTH - 2,
    parameter int unsigned AE_LEVEL  = 1,
    parameter bit          FWFT      = 1'b0,
    parameter bit          EDGE_MODE = 1'b1
) (
    input  logic                            WR_CLK,
    input  logic                            reset,
    input  logic                            CLR,
    input  logic [DATA_W-1:0]               DIN,
    input  logic                            WR_EN,
    input  logic                            RD_EN,
    input  logic                            ERR_CLR,
    output logic [DATA_W-1:0]               DOUT,
    output logic                            DOUT_VALID,
    output logic                            FULL,
    output logic                            EMPTY,
    output logic                            ALMOST_FULL,
    output logic                            ALMOST_EMPTY,
    output logic [fifo_level_w(DEPTH)-1:0]  LEVEL,
    output logic                            WR_ERR,
    output logic                            RD_ERR
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = fifo_level_w(DEPTH);

    logic              wr_req_c;
    logic              rd_req_c;
    logic              wr_acc_c;
    logic              rd_acc_c;
    logic [DATA_W-1:0] head_c;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [LVL_W-1:0]  level_q,      level_d;
    fifo_flags_t       flags_q,      flags_d;
    logic              wr_err_q,     wr_err_d;
    logic              rd_err_q,     rd_err_d;
    logic [DATA_W-1:0] dout_q,       dout_d;
    logic              dout_valid_q, dout_valid_d;

    fifo_strobe_gen #(.EDGE_MODE(EDGE_MODE)) u_wr_strobe (
        .clk     (WR_CLK),
        .rst_n   (reset),
        .level_i (WR_EN),
        .pulse_c (wr_req_c)
    );

    fifo_strobe_gen #(.EDGE_MODE(EDGE_MODE)) u_rd_strobe (
        .clk     (WR_CLK),
        .rst_n   (reset),
        .level_i (RD_EN),
        .pulse_c (rd_req_c)
    );

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        rd_acc_c = rd_req_c & ~flags_q.empty & ~CLR;
        wr_acc_c = wr_req_c & (~flags_q.full | rd_acc_c) & ~CLR;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        wr_err_d = wr_err_q;
        rd_err_d = rd_err_q;
        if (CLR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            wr_err_d = 1'b0;
            rd_err_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc_c);
            rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc_c);
            level_d  = level_q + LVL_W'(wr_acc_c) - LVL_W'(rd_acc_c);
            wr_err_d = (wr_err_q & ~ERR_CLR) | (wr_req_c & ~wr_acc_c);
            rd_err_d = (rd_err_q & ~ERR_CLR) | (rd_req_c & ~rd_acc_c);
        end
        flags_d.full         = (level_d == LVL_W'(DEPTH));
        flags_d.empty        = (level_d == '0);
        flags_d.almost_full  = (level_d >= LVL_W'(AF_LEVEL));
        flags_d.almost_empty = (level_d <= LVL_W'(AE_LEVEL));
    end

    // Fall-through head must bypass the array when it is being written this edge.
    always_comb begin
        head_c = mem_q[rd_ptr_d];
        if (wr_acc_c && (wr_ptr_q == rd_ptr_d)) begin
            head_c = DIN;
        end
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (FWFT) begin
            if (level_d != '0) begin
                dout_d = head_c;
            end
            dout_valid_d = (level_d != '0);
        end else if (rd_acc_c) begin
            dout_d       = mem_q[rd_ptr_q];
            dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge WR_CLK) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= DIN;
        end
    end

    always_ff @(posedge WR_CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            flags_q      <= FIFO_FLAGS_RST;
            wr_err_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            flags_q      <= flags_d;
            wr_err_q     <= wr_err_d;
            rd_err_q     <= rd_err_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign DOUT         = dout_q;
    assign DOUT_VALID   = dout_valid_q;
    assign FULL         = flags_q.full;
    assign EMPTY        = flags_q.empty;
    assign ALMOST_FULL  = flags_q.almost_full;
    assign ALMOST_EMPTY = flags_q.almost_empty;
    assign LEVEL        = level_q;
    assign WR_ERR       = wr_err_q;
    assign RD_ERR       = rd_err_q;

endmodule
